// File: rtl/counter_seq_pkg.sv
// Shared command, state and sizing definitions for the counter command sequencer.
// Types only; no timing or flow-control behaviour lives here.
package counter_seq_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_HOLD = 2'b11
  } cmd_op_e;

  typedef struct packed {
    cmd_op_e          op;
    logic [CNT_W-1:0] arg;
  } cmd_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  // LOAD always takes one cycle; the other ops run arg cycles, with 0 meaning 2^CNT_W.
  function automatic logic [CNT_W:0] exec_cycles(input cmd_t c);
    if (c.op == OP_LOAD) return (CNT_W+1)'(1);
    if (c.arg == '0) return (CNT_W+1)'(1) << CNT_W;
    return {1'b0, c.arg};
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with a fall-through read port.
// Push lands in one cycle; full/empty are registered, so a pop frees a slot only from the next cycle on.
module cmd_fifo
  import counter_seq_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type dat_t = cmd_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  dat_t din,
  input  logic pop,
  output dat_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  dat_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok)      count_nxt = count + 1'b1;
    else if (pop_ok && !push_ok) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Report full while in reset so nothing can be accepted until it is released.
      full   <= 1'b1;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/four_bit_counter.sv
// Four-bit up/down counter with synchronous parallel load.
// Updates every rising edge: S=1 loads D, otherwise steps in the up_and_down direction.
module four_bit_counter (
  input  logic       clk,
  input  logic       S,
  input  logic [3:0] D,
  input  logic       up_and_down,
  output logic [3:0] qout
);

  always_ff @(posedge clk) begin
    if (S)                qout <= D;
    else if (up_and_down) qout <= qout + 1'b1;
    else                  qout <= qout - 1'b1;
  end

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Turns buffered LOAD/UP/DOWN/HOLD commands into per-cycle S/D/up_and_down drive for four_bit_counter.
// Accept-to-first-drive is 2 cycles from idle; cmd_ready drops while the command buffer is full.
module counter_cmd_sequencer
  import counter_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  output logic             S,
  output logic [CNT_W-1:0] D,
  output logic             up_and_down,
  output logic [CNT_W-1:0] q_exp,
  output logic             busy,
  output logic             done
);

  cmd_t             push_dat;
  cmd_t             fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  state_e           state;
  cmd_t             cur;
  logic [CNT_W:0]   rem;
  logic             last;
  logic             pop_now;
  logic             drv_vld;
  cmd_t             drv_cmd;
  logic [CNT_W-1:0] q_nxt;

  assign push_dat  = '{op: cmd_op_e'(cmd_op), arg: cmd_arg};
  assign cmd_ready = !fifo_full;
  assign busy      = (state == ST_EXEC) || !fifo_empty;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .dat_t (cmd_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid && cmd_ready),
    .din   (push_dat),
    .pop   (pop_now),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign last    = (state == ST_EXEC) && (rem == (CNT_W+1)'(1));
  assign pop_now = !fifo_empty && ((state == ST_IDLE) || last);

  // Same update the counter applies on this edge, so q_exp tracks qout with no skew.
  assign q_nxt = S ? D : (up_and_down ? q_exp + 1'b1 : q_exp - 1'b1);

  always_comb begin
    drv_vld = 1'b0;
    drv_cmd = cur;
    if (pop_now) begin
      drv_vld = 1'b1;
      drv_cmd = fifo_dout;
    end else if ((state == ST_EXEC) && !last) begin
      drv_vld = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cur         <= '0;
      rem         <= '0;
      S           <= 1'b1;
      D           <= '0;
      up_and_down <= 1'b0;
      q_exp       <= '0;
      done        <= 1'b0;
    end else begin
      q_exp <= q_nxt;
      done  <= last;
      state <= drv_vld ? ST_EXEC : ST_IDLE;

      if (pop_now) begin
        cur <= fifo_dout;
        rem <= exec_cycles(fifo_dout);
      end else if (state == ST_EXEC) begin
        rem <= rem - 1'b1;
      end

      if (drv_vld) begin
        case (drv_cmd.op)
          OP_LOAD: begin
            S <= 1'b1;
            D <= drv_cmd.arg;
          end
          OP_UP: begin
            S           <= 1'b0;
            D           <= q_nxt;
            up_and_down <= 1'b1;
          end
          OP_DOWN: begin
            S           <= 1'b0;
            D           <= q_nxt;
            up_and_down <= 1'b0;
          end
          OP_HOLD: begin
            S <= 1'b1;
            D <= q_nxt;
          end
        endcase
      end else begin
        // Idle: reload the current value so the counter stands still.
        S <= 1'b1;
        D <= q_nxt;
      end
    end
  end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Directed bench: counter_cmd_sequencer driving four_bit_counter, qout checked against q_exp every cycle.
module tb_counter_cmd_sequencer;

  localparam logic [1:0] LOAD = 2'b00;
  localparam logic [1:0] UP   = 2'b01;
  localparam logic [1:0] DOWN = 2'b10;
  localparam logic [1:0] HOLD = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;
  logic       S;
  logic [3:0] D;
  logic       up_and_down;
  logic [3:0] q_exp;
  logic       busy;
  logic       done;
  logic [3:0] qout;

  int n_chk    = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int d0       = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  counter_cmd_sequencer #(
    .FIFO_DEPTH (2),
    .CNT_W      (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_arg     (cmd_arg),
    .S           (S),
    .D           (D),
    .up_and_down (up_and_down),
    .q_exp       (q_exp),
    .busy        (busy),
    .done        (done)
  );

  four_bit_counter u_cnt (
    .clk         (clk),
    .S           (S),
    .D           (D),
    .up_and_down (up_and_down),
    .qout        (qout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] arg);
    bit acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (mon_en) chk("qout_mirror", qout, q_exp);
    if (done) done_cnt++;
  end

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = LOAD;
    cmd_arg   = 4'd0;

    // 1: reset and release
    tick();
    tick();
    chk("rst_ready_low", cmd_ready, 0);
    chk("rst_S", S, 1);
    chk("rst_done", done, 0);
    reset = 1'b1;
    tick();
    chk("rel_S", S, 1);
    chk("rel_D", D, 0);
    chk("rel_q_exp", q_exp, 0);
    chk("rel_busy", busy, 0);
    chk("rel_ready", cmd_ready, 1);
    chk("rel_qout", qout, 0);
    mon_en = 1'b1;

    // 2: LOAD 5 then UP 3
    d0 = done_cnt;
    push(LOAD, 4'd5);
    push(UP, 4'd3);
    chk("t2_load_S", S, 1);
    chk("t2_load_D", D, 5);
    tick();
    chk("t2_q5", q_exp, 5);
    chk("t2_done_load", done, 1);
    chk("t2_dir_up", up_and_down, 1);
    tick();
    chk("t2_q6", q_exp, 6);
    chk("t2_nodone", done, 0);
    tick();
    chk("t2_q7", q_exp, 7);
    tick();
    chk("t2_q8", q_exp, 8);
    chk("t2_qout8", qout, 8);
    chk("t2_done_up", done, 1);
    chk("t2_busy_off", busy, 0);
    tick();
    chk("t2_done_cnt", done_cnt - d0, 2);

    // 3: LOAD 1 then DOWN 3, wrapping below zero
    push(LOAD, 4'd1);
    push(DOWN, 4'd3);
    tick();
    chk("t3_q1", q_exp, 1);
    chk("t3_S_down", S, 0);
    tick();
    chk("t3_q0", q_exp, 0);
    chk("t3_S_hold0", S, 0);
    tick();
    chk("t3_q15", q_exp, 15);
    chk("t3_S_hold1", S, 0);
    tick();
    chk("t3_q14", q_exp, 14);
    chk("t3_done", done, 1);
    chk("t3_S_idle", S, 1);

    // 4: UP with arg 0 runs 16 cycles
    push(LOAD, 4'd3);
    push(UP, 4'd0);
    tick();
    chk("t4_q3", q_exp, 3);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("t4_q", q_exp, (3 + i) % 16);
      chk("t4_done", done, (i == 16) ? 1 : 0);
      chk("t4_S", S, (i == 16) ? 1 : 0);
    end

    // 5: buffer fills behind HOLD 4, fourth command waits for a slot
    cmd_valid = 1'b1;
    cmd_op = HOLD; cmd_arg = 4'd4;
    tick();
    chk("t5_ready_e1", cmd_ready, 1);
    cmd_op = UP; cmd_arg = 4'd2;
    tick();
    chk("t5_ready_e2", cmd_ready, 1);
    chk("t5_hold_S", S, 1);
    chk("t5_hold_D", D, 3);
    chk("t5_busy", busy, 1);
    cmd_op = DOWN; cmd_arg = 4'd1;
    tick();
    chk("t5_full_e3", cmd_ready, 0);
    cmd_op = LOAD; cmd_arg = 4'd9;
    tick();
    chk("t5_full_e4", cmd_ready, 0);
    chk("t5_hold_D4", D, 3);
    tick();
    chk("t5_full_e5", cmd_ready, 0);
    chk("t5_nodone_e5", done, 0);
    tick();
    chk("t5_done_hold", done, 1);
    chk("t5_ready_free", cmd_ready, 1);
    chk("t5_q_hold", q_exp, 3);
    tick();
    cmd_valid = 1'b0;
    d0 = done_cnt;
    chk("t5_q4", q_exp, 4);
    chk("t5_busy7", busy, 1);
    tick();
    chk("t5_q5", q_exp, 5);
    chk("t5_done_up", done, 1);
    chk("t5_busy8", busy, 1);
    tick();
    chk("t5_q4b", q_exp, 4);
    chk("t5_done_down", done, 1);
    chk("t5_busy9", busy, 1);
    tick();
    chk("t5_q9", q_exp, 9);
    chk("t5_done_load", done, 1);
    chk("t5_busy_off", busy, 0);
    tick();
    chk("t5_done_cnt", done_cnt - d0, 3);

    // 6: reset in the middle of UP 8 with two commands queued
    push(UP, 4'd8);
    push(UP, 4'd1);
    push(HOLD, 4'd2);
    tick();
    chk("t6_q11", q_exp, 11);
    chk("t6_full", cmd_ready, 0);
    d0 = done_cnt;
    mon_en = 1'b0;
    reset = 1'b0;
    tick();
    chk("t6_rst_S", S, 1);
    chk("t6_rst_D", D, 0);
    chk("t6_rst_q", q_exp, 0);
    chk("t6_rst_dir", up_and_down, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", cmd_ready, 0);
    reset = 1'b1;
    tick();
    chk("t6_rel_ready", cmd_ready, 1);
    chk("t6_rel_busy", busy, 0);
    chk("t6_rel_q", q_exp, 0);
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t6_q_stays", q_exp, 0);
      chk("t6_busy_stays", busy, 0);
    end
    chk("t6_no_done", done_cnt - d0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/counter_cmd_sequencer.md
Name: counter_cmd_sequencer

Overview:
Upstream command stage for four_bit_counter. It accepts load, count-up, count-down and hold commands over a valid/ready handshake and buffers them in a 2-entry FIFO. It drives the counter's S, D and up_and_down inputs cycle by cycle. It also keeps a mirror of the counter value so downstream logic and the bench can check qout without reading the counter.

Parameters:
FIFO_DEPTH, 2, command buffer entries (power of 2, min 2)
CNT_W, 4, counter/argument width; must match four_bit_counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  buffer can accept; high when FIFO not full
cmd_op  in  2  00 LOAD, 01 UP, 10 DOWN, 11 HOLD
cmd_arg  in  CNT_W  LOAD: value; UP/DOWN/HOLD: cycle count, 0 means 16
S  out  1  counter load select; 1 = load D
D  out  CNT_W  counter load value
up_and_down  out  1  counter direction; 1 = up, 0 = down
q_exp  out  CNT_W  mirror of counter qout, zero skew
busy  out  1  command executing or FIFO non-empty
done  out  1  one-cycle pulse after a command's last execute cycle

Behaviour:
- Reset is sampled on the rising clk edge while reset==0. It drives:
  - S=1, D=0, up_and_down=0, q_exp=0, done=0, busy=0.
  - FIFO flushed, FSM to IDLE.
  - cmd_ready=0 while reset is low.
- Reset takes effect mid-command too: the command is aborted, buffered commands are discarded, and no done pulse is issued.
- Handshake: a command is accepted on an edge where cmd_valid && cmd_ready. It is written to the FIFO tail. The sender must hold op/arg stable while valid is high and ready is low.
- Simultaneous push and pop with the FIFO full is allowed; ready reflects the registered full flag only (no bypass).
- All outputs are registered.
- FSM states:
  - IDLE: S=1, D=q_exp, so the counter holds. If the FIFO is non-empty, pop and go to EXEC. The first execute cycle is the cycle after the pop, so latency from accept to first drive is 2 cycles when empty and idle.
  - EXEC: drive per op.
    - LOAD: S=1, D=arg, for 1 cycle.
    - UP: S=0, up_and_down=1, for N cycles.
    - DOWN: S=0, up_and_down=0, for N cycles.
    - HOLD: S=1, D=q_exp, for N cycles.
    - N = arg, or 16 when arg=0.
    - On the last execute cycle, pop the next command if one is present and continue in EXEC with no gap. Otherwise go to IDLE.
- up_and_down keeps its last value outside UP/DOWN.
- done=1 in the cycle after each command's last execute cycle. Back-to-back commands produce back-to-back done pulses.
- q_exp update, on each edge using the currently driven outputs:
  - S=1: q_exp <= D.
  - S=0 and up: q_exp <= q_exp+1, mod 16.
  - S=0 and down: q_exp <= q_exp-1, mod 16.
  - This matches four_bit_counter sampling the same signals on the same edge.
- Wrap-around is silent modulo 2^CNT_W. There is no overflow flag.
- The internal per-command cycle counter is CNT_W+1 bits wide so it can hold 16.
- busy = (state==EXEC) || !fifo_empty.

Decomposition:
- Package counter_seq_pkg:
  - typedef enum cmd_op_e {OP_LOAD, OP_UP, OP_DOWN, OP_HOLD}
  - typedef struct cmd_t {op, arg}
  - state enum {ST_IDLE, ST_EXEC}
  - constant CNT_W=4
- Sub-module cmd_fifo: synchronous FIFO parameterised by depth and cmd_t.
  - Ports: push, pop, full, empty, dout.
  - Same active-low synchronous reset.
- Top level holds the FSM, cycle counter and q_exp.
- The bench instantiates counter_cmd_sequencer feeding four_bit_counter and asserts qout==q_exp every cycle after reset release.

Test Plan:
1. Reset low 2 cycles, then release -> S=1, D=0, q_exp=0, busy=0, cmd_ready=1 on the first cycle after release; counter qout=0.
2. LOAD 5, then UP arg=3 -> q_exp and qout go 5,6,7,8; two done pulses; busy drops after the last done.
3. LOAD 1, then DOWN arg=3 -> q_exp goes 1,0,15,14; wrap with no glitch on S.
4. UP arg=0 starting from 3 -> exactly 16 count cycles; q_exp returns to 3; one done.
5. Push 3 commands back-to-back while the first executes (HOLD arg=4) -> cmd_ready low while the FIFO is full; the held command is accepted once a slot frees; no idle cycle between commands; done count=3.
6. Reset asserted mid UP arg=8 with 2 commands queued -> next cycle S=1, D=0, q_exp=0; FIFO empty; no done pulse; queued commands never execute.
